// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32I five-stage pipeline control blocks.
package rv32_pipe_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    RESOLVE = 2'd2
  } bhcState_t;

  // Cycles a branch in ID must wait before forwarding can supply its operand.
  localparam logic [1:0] STALL_NONE     = 2'd0;
  localparam logic [1:0] STALL_LOAD_EX  = 2'd2;
  localparam logic [1:0] STALL_ALU_EX   = 2'd1;
  localparam logic [1:0] STALL_LOAD_MEM = 2'd1;

  function automatic logic [1:0] maxStall(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reg_hazard_match.sv
// Combinational RAW hit test: a producer hits a source operand when it writes
// a non-zero destination equal to that operand.
module reg_hazard_match #(
  parameter int REG_ADDR_WIDTH = rv32_pipe_pkg::REG_ADDR_WIDTH
) (
  input  logic                      regWrite,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  output logic                      hit
);

  assign hit = regWrite && (rd != '0) && (rd == rs);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/JALR hazard sequencer: stalls until operands can be forwarded,
// then flushes the wrong-path fetch on a taken outcome. `BHC_PERF_EN adds counters.
module branch_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = rv32_pipe_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic                      id_is_branch,
  input  logic                      id_is_jalr,
  input  logic                      id_taken,
  input  logic [REG_ADDR_WIDTH-1:0] ifid_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ifid_rs2,
  input  logic                      idex_RegWrite,
  input  logic                      idex_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] idex_rd,
  input  logic                      exmem_RegWrite,
  input  logic                      exmem_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      idex_bubble,
  output logic                      ifid_flush,
`ifdef BHC_PERF_EN
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_flushes,
`endif
  output logic                      stall_active
);

  import rv32_pipe_pkg::*;

  bhcState_t  state;
  logic [1:0] cnt;
  logic       exHit1, exHit2, memHit1, memHit2;
  logic       isCtl, useRs2;
  logic [1:0] needCnt;
  logic       stallReq, resolveNow;

  reg_hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_exRs1 (
    .regWrite(idex_RegWrite), .rd(idex_rd), .rs(ifid_rs1), .hit(exHit1));
  reg_hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_exRs2 (
    .regWrite(idex_RegWrite), .rd(idex_rd), .rs(ifid_rs2), .hit(exHit2));
  reg_hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_memRs1 (
    .regWrite(exmem_RegWrite), .rd(exmem_rd), .rs(ifid_rs1), .hit(memHit1));
  reg_hazard_match #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_memRs2 (
    .regWrite(exmem_RegWrite), .rd(exmem_rd), .rs(ifid_rs2), .hit(memHit2));

  assign isCtl  = id_is_branch | id_is_jalr;
  assign useRs2 = id_is_branch & ~id_is_jalr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    needCnt    = STALL_NONE;
    stallReq   = 1'b0;
    resolveNow = 1'b0;
    if (isCtl) begin
      if (exHit1 || (useRs2 && exHit2))
        needCnt = idex_MemRead ? STALL_LOAD_EX : STALL_ALU_EX;
      if ((memHit1 || (useRs2 && memHit2)) && exmem_MemRead)
        needCnt = maxStall(needCnt, STALL_LOAD_MEM);
    end
    unique case (state)
      RUN: begin
        stallReq   = (needCnt != STALL_NONE);
        resolveNow = isCtl && (needCnt == STALL_NONE);
      end
      HOLD:    stallReq   = 1'b1;
      RESOLVE: resolveNow = 1'b1;
      default: ;
    endcase
  end

  // Freeze masks every enable, including the controller's own stall report.
  assign pc_write     = ~freeze & ~stallReq;
  assign ifid_write   = ~freeze & ~stallReq;
  assign idex_bubble  = ~freeze &  stallReq;
  assign stall_active = ~freeze &  stallReq;
  assign ifid_flush   = ~freeze &  resolveNow & id_taken;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (!freeze) begin
      unique case (state)
        RUN: begin
          if (stallReq) begin
            cnt   <= needCnt - 2'd1;
            state <= (needCnt > 2'd1) ? HOLD : RUN;
          end
        end
        HOLD: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          if (cnt <= 2'd1) state <= RESOLVE;
        end
        RESOLVE: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef BHC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flushes      <= 32'd0;
    end else begin
      if (stall_active && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ifid_flush && (perf_flushes != 32'hFFFF_FFFF))
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed scenarios plus random
// stimulus against an owed-stall reference model.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze, id_is_branch, id_is_jalr, id_taken;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd, exmem_rd;
  logic       idex_RegWrite, idex_MemRead, exmem_RegWrite, exmem_MemRead;
  logic       pc_write, ifid_write, idex_bubble, ifid_flush, stall_active;
`ifdef BHC_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
  logic [31:0] mPerfStall, mPerfFlush;
`endif
  logic [4:0] outs;

  int  passCount = 0;
  int  totalCount = 0;
  int  owed, nOwed;
  bit  resolvePending, nRes;
  bit  eStall, eFlush;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .id_is_branch(id_is_branch), .id_is_jalr(id_is_jalr), .id_taken(id_taken),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_RegWrite(idex_RegWrite), .idex_MemRead(idex_MemRead), .idex_rd(idex_rd),
    .exmem_RegWrite(exmem_RegWrite), .exmem_MemRead(exmem_MemRead), .exmem_rd(exmem_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush),
`ifdef BHC_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
`endif
    .stall_active(stall_active));

  assign outs = {pc_write, ifid_write, idex_bubble, ifid_flush, stall_active};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic setIdle();
    freeze = 0; id_is_branch = 0; id_is_jalr = 0; id_taken = 0;
    ifid_rs1 = 0; ifid_rs2 = 0;
    idex_RegWrite = 0; idex_MemRead = 0; idex_rd = 0;
    exmem_RegWrite = 0; exmem_MemRead = 0; exmem_rd = 0;
  endtask

  task automatic modelReset();
    owed = 0; resolvePending = 0;
`ifdef BHC_PERF_EN
    mPerfStall = 0; mPerfFlush = 0;
`endif
  endtask

  // Worst-case wait over the source operands this instruction actually reads.
  function automatic int needStalls();
    int n = 0;
    logic [4:0] ops[2];
    ops[0] = ifid_rs1;
    ops[1] = ifid_rs2;
    if (!(id_is_branch || id_is_jalr)) return 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1 && (id_is_jalr || !id_is_branch)) continue;
      if (idex_RegWrite && idex_rd != 0 && idex_rd == ops[i])
        n = (idex_MemRead ? 2 : 1) > n ? (idex_MemRead ? 2 : 1) : n;
      if (exmem_RegWrite && exmem_MemRead && exmem_rd != 0 && exmem_rd == ops[i])
        n = (n > 1) ? n : 1;
    end
    return n;
  endfunction

  // Evaluate the model for the current inputs and compare all outputs.
  task automatic evalCompare();
    int n;
    logic [4:0] expOuts;
    #1;
    eStall = 0; eFlush = 0;
    nOwed = owed; nRes = resolvePending;
    n = needStalls();
    if (owed > 0) begin
      eStall = 1; nOwed = owed - 1;
    end else if (resolvePending) begin
      eFlush = id_taken; nRes = 0;
    end else if (n == 0) begin
      eFlush = (id_is_branch || id_is_jalr) && id_taken;
    end else begin
      eStall = 1;
      if (n >= 2) begin nOwed = n - 1; nRes = 1; end
    end
    if (freeze) begin
      eStall = 0; eFlush = 0; nOwed = owed; nRes = resolvePending;
      expOuts = 5'b00000;
    end else begin
      expOuts = {~eStall, ~eStall, eStall, eFlush, eStall};
    end
    check("outputs", {27'd0, outs}, {27'd0, expOuts});
`ifdef BHC_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, mPerfStall);
    check("perf_flushes", perf_flushes, mPerfFlush);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    owed = nOwed; resolvePending = nRes;
`ifdef BHC_PERF_EN
    if (eStall && mPerfStall != 32'hFFFF_FFFF) mPerfStall++;
    if (eFlush && mPerfFlush != 32'hFFFF_FFFF) mPerfFlush++;
`endif
    #1;
  endtask

  // Reset asserted mid-cycle must take effect without waiting for a clock edge.
  task automatic midReset();
    rst = 1; setIdle();
    #1;
    check("reset_outputs", {27'd0, outs}, {27'd0, 5'b11000});
    modelReset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    setIdle();
    rst = 1;
    modelReset();
    #2;
    check("reset_idle_outputs", {27'd0, outs}, {27'd0, 5'b11000});
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // BEQ x1,x2 with add x1 in EX: one stall, then taken resolves with flush.
    id_is_branch = 1; ifid_rs1 = 1; ifid_rs2 = 2;
    idex_RegWrite = 1; idex_rd = 1;
    evalCompare();
    check("alu_ex_pc_write", pc_write, 0);
    check("alu_ex_bubble", idex_bubble, 1);
    tick();
    idex_RegWrite = 0; idex_rd = 0; exmem_RegWrite = 1; exmem_rd = 1; id_taken = 1;
    evalCompare();
    check("alu_ex_flush", ifid_flush, 1);
    check("alu_ex_resolve_pc", pc_write, 1);
    tick();
    setIdle(); evalCompare(); tick();

    // BNE on x5 with lw x5 in EX: two stalls, then not-taken resolve.
    id_is_branch = 1; ifid_rs1 = 5; ifid_rs2 = 6;
    idex_RegWrite = 1; idex_MemRead = 1; idex_rd = 5;
    evalCompare();
    check("load_ex_stall1", idex_bubble, 1);
    tick();
    idex_RegWrite = 0; idex_MemRead = 0; idex_rd = 0;
    exmem_RegWrite = 1; exmem_MemRead = 1; exmem_rd = 5;
    evalCompare();
    check("load_ex_stall2", stall_active, 1);
    tick();
    exmem_RegWrite = 0; exmem_MemRead = 0; exmem_rd = 0;
    evalCompare();
    check("load_ex_resolve", {30'd0, pc_write, ifid_flush}, 32'd2);
    tick();
    setIdle(); evalCompare(); tick();

    // JALR: rd=0 producer and an rs2-only hazard both leave the pipe running.
    id_is_jalr = 1; ifid_rs1 = 0; idex_RegWrite = 1; idex_rd = 0;
    evalCompare();
    check("jalr_rd0_nostall", pc_write, 1);
    tick();
    ifid_rs1 = 7; ifid_rs2 = 4; idex_rd = 4;
    evalCompare();
    check("jalr_rs2_nostall", idex_bubble, 0);
    tick();
    setIdle(); evalCompare(); tick();

    // lw x3 in EX, BEQ x3, freeze for three cycles while in HOLD.
    id_is_branch = 1; ifid_rs1 = 3; ifid_rs2 = 0;
    idex_RegWrite = 1; idex_MemRead = 1; idex_rd = 3;
    evalCompare();
    check("freeze_seq_stall_a", idex_bubble, 1);
    tick();
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      evalCompare();
      check("freeze_no_advance", {30'd0, pc_write, idex_bubble}, 32'd0);
      tick();
    end
    freeze = 0;
    idex_RegWrite = 0; idex_MemRead = 0; idex_rd = 0;
    exmem_RegWrite = 1; exmem_MemRead = 1; exmem_rd = 3;
    evalCompare();
    check("freeze_seq_stall_b", idex_bubble, 1);
    tick();
    exmem_RegWrite = 0; exmem_MemRead = 0; exmem_rd = 0;
    evalCompare();
    check("freeze_seq_resolve", pc_write, 1);
    tick();
    setIdle(); evalCompare(); tick();

    // Reset while in HOLD, then no residual stall.
    id_is_branch = 1; ifid_rs1 = 9; idex_RegWrite = 1; idex_MemRead = 1; idex_rd = 9;
    evalCompare(); tick();
    midReset();
    evalCompare();
    check("post_reset_no_stall", stall_active, 0);
    tick();

    // Randomized phase: small register numbers to make hits frequent.
    for (int c = 0; c < 3000; c++) begin
      int kind;
      if ($urandom_range(0, 299) == 0) begin
        midReset();
        continue;
      end
      kind = $urandom_range(0, 3);
      id_is_branch   = (kind == 1) || (kind == 3);
      id_is_jalr     = (kind == 2);
      id_taken       = 1'($urandom_range(0, 1));
      freeze         = ($urandom_range(0, 7) == 0);
      ifid_rs1       = 5'($urandom_range(0, 3));
      ifid_rs2       = 5'($urandom_range(0, 3));
      idex_RegWrite  = 1'($urandom_range(0, 1));
      idex_MemRead   = 1'($urandom_range(0, 1));
      idex_rd        = 5'($urandom_range(0, 3));
      exmem_RegWrite = 1'($urandom_range(0, 1));
      exmem_MemRead  = 1'($urandom_range(0, 1));
      exmem_rd       = 5'($urandom_range(0, 3));
      evalCompare();
      tick();
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Sequences the ID-stage branch/jump resolution path of the RV32I five-stage pipeline. Detects read-after-write hazards between a branch or JALR in ID and older producers in EX or MEM, then holds PC and IF/ID while bubbling ID/EX for exactly the cycles needed until forwarding can supply operands. When the branch resolves taken, it flushes the wrong-path fetch. Sits beside the branch forwarding and comparator logic in ID and drives the pipeline-register write enables.

## Interface
- `REG_ADDR_WIDTH`, default 5: register index width.
- `clk` input 1: pipeline clock.
- `rst` input 1: asynchronous, active-high reset.
- `freeze` input 1: global pipeline freeze (memory busy); holds everything.
- `id_is_branch` input 1: ID holds a conditional branch (B-type).
- `id_is_jalr` input 1: ID holds JALR; uses rs1 only.
- `id_taken` input 1: comparator/jump outcome, valid only when operands are final.
- `ifid_rs1`, `ifid_rs2` input REG_ADDR_WIDTH: ID source registers.
- `idex_RegWrite`, `idex_MemRead` input 1; `idex_rd` input REG_ADDR_WIDTH: producer in EX.
- `exmem_RegWrite`, `exmem_MemRead` input 1; `exmem_rd` input REG_ADDR_WIDTH: producer in MEM.
- `pc_write` output 1: PC update enable.
- `ifid_write` output 1: IF/ID write enable.
- `idex_bubble` output 1: load NOP into ID/EX.
- `ifid_flush` output 1: clear IF/ID (wrong-path fetch).
- `stall_active` output 1: controller is holding ID.

## Operation
- Match: producer stage P hits operand rs when P_RegWrite=1, P_rd≠0, P_rd==rs. rs2 is checked only for branches, never for JALR.
- Required stalls N: EX hit with idex_MemRead=1 → 2. EX hit with ALU result → 1. MEM hit with exmem_MemRead=1 → 1. Otherwise 0. Take the maximum over rs1/rs2 and stages.
- FSM states:
  - RUN: if (branch|jalr) and N>0: stall this cycle, load cnt=N-1, go to HOLD if N-1>0, else stay in RUN.
  - RUN, if (branch|jalr) and N=0: resolve. `ifid_flush`=`id_taken`.
  - HOLD: stall. cnt decrements. When cnt reaches 0, go to RESOLVE.
  - RESOLVE: no stall. `ifid_flush`=`id_taken`. Go to RUN.
- In RUN, hazards are re-evaluated every cycle. Re-evaluating after a 1-cycle stall naturally finds N=0.
- Stall outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `stall_active`=1.
- No stall: `pc_write`=1, `ifid_write`=1, `idex_bubble`=0.
- Flush and stall are mutually exclusive. A flush never occurs while stalled.
- `freeze`=1 overrides everything:
  - `pc_write`=`ifid_write`=0, `idex_bubble`=0, `ifid_flush`=0.
  - State and cnt hold.
  - Hazard detection does not load cnt.
- Non-branch instructions never stall here; load-use for ALU ops is handled elsewhere.

## Timing
- Outputs are combinational from state, cnt and current inputs (Mealy). The stall asserts in the same cycle the hazard is visible.
- Latency from a hazardous branch entering ID to resolution is N cycles. Flush asserts in the resolution cycle.
- cnt is 2 bits.
- Reset (async, any state including mid-HOLD): state=RUN, cnt=0.
- Outputs after reset with idle inputs: `pc_write`=1, `ifid_write`=1, `idex_bubble`=0, `ifid_flush`=0, `stall_active`=0.
- `freeze` asserted mid-HOLD extends the stall by the freeze length with no lost count. Deassert resumes the decrement.

## Configuration
- `BHC_PERF_EN` defined adds two outputs, each 32 bits, saturating at 0xFFFFFFFF, reset to 0:
  - `perf_stall_cycles`: increments per non-frozen stall cycle.
  - `perf_flushes`: increments per asserted `ifid_flush`.
- `BHC_PERF_EN` undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Shared package `rv32_pipe_pkg` holds:
  - `REG_ADDR_WIDTH`.
  - State enum (RUN, HOLD, RESOLVE).
  - Stall constants: `STALL_LOAD_EX`=2, `STALL_ALU_EX`=1, `STALL_LOAD_MEM`=1.
- One sub-module, `reg_hazard_match`: combinational hit test (RegWrite, rd≠0, rd==rs). Instantiated four times.

## Test plan
- BEQ x1,x2 with `add x1` in EX (idex_RegWrite=1, rd=1) → 1 stall cycle (`pc_write`=0, `idex_bubble`=1). Next cycle `id_taken`=1 → `ifid_flush`=1.
- BNE using x5 with `lw x5` in EX → 2 stall cycles (HOLD entered, cnt 1→0), then RESOLVE. `id_taken`=0 → no flush.
- JALR x0,0(x0) with EX rd=0, RegWrite=1 → no stall. Hazard on rs2 only with JALR → no stall.
- `lw x3` in EX, BEQ x3: assert `freeze` for 3 cycles in HOLD → 5 total non-advancing cycles. Bubble only on the 2 non-frozen stall cycles.
- Reset asserted in HOLD → outputs immediately at reset values. After release, no residual stall.
- With `BHC_PERF_EN`: the above sequence yields `perf_stall_cycles`=5 and `perf_flushes`=1. Saturation is checked by forcing the counter to 0xFFFFFFFE.
